// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, NOP encodings and
// the legal range of the branch penalty.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush   = 2'd1,
        StMemWait = 2'd2
    } hcu_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0
    localparam logic [3:0]  ALU_NOP   = 4'hF;

    localparam int unsigned BRANCH_PENALTY_MIN = 1;
    localparam int unsigned BRANCH_PENALTY_MAX = 3;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter32 (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] r_count;

    // Clear has priority; increment only while below the saturation value.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle branch flushes and
// data-memory wait freezes. Define HAZARD_PERF_CNT_EN to build the three
// performance counters; otherwise the perf ports are tied to zero.
module hazard_control_unit
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned MEM_TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_branch_taken,
    input  logic        mem_req_valid,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        pipeline_stall,
    output logic        id_ex_hold,
    output logic        mem_timeout_err,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events,
    output logic [31:0] perf_load_use_events
);

    // Out-of-range penalties are clamped into the supported window.
    localparam int unsigned BpEff =
        (BRANCH_PENALTY < BRANCH_PENALTY_MIN) ? BRANCH_PENALTY_MIN :
        (BRANCH_PENALTY > BRANCH_PENALTY_MAX) ? BRANCH_PENALTY_MAX : BRANCH_PENALTY;
    localparam int unsigned WaitW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0]       FlushReload = 2'(BpEff - 1);
    localparam logic [WaitW-1:0] WaitMax     = WaitW'(MEM_TIMEOUT);

    hcu_state_e       r_state, w_state_d;
    hcu_state_e       r_ret_state, w_ret_state_d;
    logic [1:0]       r_flush_cnt, w_flush_cnt_d;
    logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_d;
    logic             r_err;

    logic w_mem_miss, w_load_use;
    logic w_freeze, w_do_run, w_do_flush;
    logic w_pc_write, w_if_id_write, w_if_id_flush, w_pipeline_stall, w_id_ex_hold;

    assign w_mem_miss = mem_req_valid && !mem_ready;
    assign w_load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                        ((id_uses_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                         (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));

    // Pick which rule set governs this cycle, then apply it to outputs and next state.
    always_comb begin
        w_pc_write       = 1'b1;
        w_if_id_write    = 1'b1;
        w_if_id_flush    = 1'b0;
        w_pipeline_stall = 1'b0;
        w_id_ex_hold     = 1'b0;
        w_state_d        = r_state;
        w_ret_state_d    = r_ret_state;
        w_flush_cnt_d    = r_flush_cnt;
        w_wait_cnt_d     = '0;
        w_freeze         = 1'b0;
        w_do_run         = 1'b0;
        w_do_flush       = 1'b0;

        unique case (r_state)
            StRun: begin
                if (w_mem_miss) begin
                    w_freeze      = 1'b1;
                    w_state_d     = StMemWait;
                    w_ret_state_d = StRun;
                end else begin
                    w_do_run = 1'b1;
                end
            end
            StFlush: begin
                if (w_mem_miss) begin
                    w_freeze      = 1'b1;
                    w_state_d     = StMemWait;
                    w_ret_state_d = StFlush;
                end else begin
                    w_do_flush = 1'b1;
                end
            end
            StMemWait: begin
                if (!mem_ready) begin
                    w_freeze = 1'b1;
                end else if ((r_ret_state == StFlush) && (r_flush_cnt != 2'd0)) begin
                    w_do_flush = 1'b1;
                end else begin
                    w_do_run = 1'b1;
                end
            end
            default: begin
                w_do_run = 1'b1;
            end
        endcase

        if (w_freeze) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_hold  = 1'b1;
            w_wait_cnt_d  = (r_wait_cnt != WaitMax) ? (r_wait_cnt + WaitW'(1)) : r_wait_cnt;
        end

        // A taken branch (re)starts the flush window from either rule set.
        if ((w_do_run || w_do_flush) && ex_branch_taken) begin
            w_if_id_flush    = 1'b1;
            w_pipeline_stall = 1'b1;
            w_flush_cnt_d    = FlushReload;
            w_state_d        = (BpEff > 1) ? StFlush : StRun;
        end else if (w_do_flush) begin
            w_if_id_flush    = 1'b1;
            w_pipeline_stall = 1'b1;
            w_flush_cnt_d    = r_flush_cnt - 2'd1;
            w_state_d        = (r_flush_cnt <= 2'd1) ? StRun : StFlush;
        end else if (w_do_run) begin
            w_state_d = StRun;
            if (w_load_use) begin
                w_pc_write       = 1'b0;
                w_if_id_write    = 1'b0;
                w_pipeline_stall = 1'b1;
            end
        end
    end

    // State, counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StRun;
            r_ret_state <= StRun;
            r_flush_cnt <= 2'd0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ret_state <= w_ret_state_d;
            r_flush_cnt <= w_flush_cnt_d;
            r_wait_cnt  <= w_wait_cnt_d;
            r_err       <= r_err | (w_wait_cnt_d == WaitMax);
        end
    end

    // Reset forces every output low, including the enables.
    assign pc_write        = !rst && w_pc_write;
    assign if_id_write     = !rst && w_if_id_write;
    assign if_id_flush     = !rst && w_if_id_flush;
    assign pipeline_stall  = !rst && w_pipeline_stall;
    assign id_ex_hold      = !rst && w_id_ex_hold;
    assign mem_timeout_err = !rst && r_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] w_cnt_stall, w_cnt_flush, w_cnt_lu;
    logic        w_branch_svc, w_lu_bubble;

    // Flush with a taken branch in EX is a serviced branch; a stall without
    // flush or hold is a load-use bubble.
    assign w_branch_svc = w_if_id_flush && ex_branch_taken;
    assign w_lu_bubble  = w_pipeline_stall && !w_if_id_flush && !w_id_ex_hold;

    sat_counter32 u_cnt_stall (
        .clk   (clk),
        .clr   (rst),
        .en    (!w_pc_write),
        .count (w_cnt_stall)
    );

    sat_counter32 u_cnt_flush (
        .clk   (clk),
        .clr   (rst),
        .en    (w_branch_svc),
        .count (w_cnt_flush)
    );

    sat_counter32 u_cnt_lu (
        .clk   (clk),
        .clr   (rst),
        .en    (w_lu_bubble),
        .count (w_cnt_lu)
    );

    assign perf_stall_cycles    = rst ? 32'd0 : w_cnt_stall;
    assign perf_flush_events    = rst ? 32'd0 : w_cnt_flush;
    assign perf_load_use_events = rst ? 32'd0 : w_cnt_lu;
`else
    assign perf_stall_cycles    = 32'd0;
    assign perf_flush_events    = 32'd0;
    assign perf_load_use_events = 32'd0;
`endif

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller that drives the `pipeline_stall` bubble input of the ID/EX register and the write, flush and hold enables of PC, IF/ID and ID/EX. It consumes the ID/EX register outputs (EX-stage load and destination info), ID-stage source addresses, the EX branch-taken flag and the MEM-stage data-memory handshake. It resolves load-use stalls, multi-cycle branch flushes and shared-memory wait freezes, and one instance sits in each core.

## Interface
- `BRANCH_PENALTY`, default 1: number of consecutive IF/ID flush cycles per taken branch; legal range 1..3.
- `MEM_TIMEOUT`, default 255: wait-cycle count at which `mem_timeout_err` sets.
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset.
- `id_rs1_addr` input 5: ID-stage rs1.
- `id_rs2_addr` input 5: ID-stage rs2.
- `id_uses_rs1` input 1: ID instruction reads rs1.
- `id_uses_rs2` input 1: ID instruction reads rs2.
- `ex_mem_read` input 1: EX instruction is a load.
- `ex_rd_addr` input 5: EX destination register.
- `ex_branch_taken` input 1: EX redirects the PC this cycle.
- `mem_req_valid` input 1: MEM stage issues a data access.
- `mem_ready` input 1: memory/bus accepts or completes the access.
- `pc_write` output 1: PC register enable.
- `if_id_write` output 1: IF/ID enable.
- `if_id_flush` output 1: load NOP into IF/ID.
- `pipeline_stall` output 1: insert a bubble into ID/EX.
- `id_ex_hold` output 1: freeze ID/EX and all later stage registers; takes priority over `pipeline_stall`.
- `mem_timeout_err` output 1: sticky error flag.
- `perf_stall_cycles` output 32: perf counter.
- `perf_flush_events` output 32: perf counter.
- `perf_load_use_events` output 32: perf counter.

## Operation
- Internal state: FSM `{RUN, FLUSH, MEM_WAIT}`; 2-bit `flush_cnt`; `ret_state` register; `wait_cnt` saturating at `MEM_TIMEOUT`.
- Definitions:
  - `mem_miss` = `mem_req_valid && !mem_ready`.
  - `load_use` = `ex_mem_read && ex_rd_addr != 0 && ((id_uses_rs1 && ex_rd_addr == id_rs1_addr) || (id_uses_rs2 && ex_rd_addr == id_rs2_addr))`.
- Default outputs: `pc_write` = 1, `if_id_write` = 1, all others 0.
- Priority in every state: `mem_miss` > branch or flush > `load_use`.

**RUN**
- On `mem_miss`:
  - Outputs: `pc_write` = 0, `if_id_write` = 0, `id_ex_hold` = 1.
  - Next state MEM_WAIT; `ret_state` = RUN.
- On `ex_branch_taken`:
  - Outputs: `if_id_flush` = 1, `pipeline_stall` = 1, `pc_write` = 1.
  - If `BRANCH_PENALTY` > 1: next state FLUSH with `flush_cnt` = `BRANCH_PENALTY` - 1.
- On `load_use`:
  - Outputs: `pc_write` = 0, `if_id_write` = 0, `pipeline_stall` = 1.
  - Exactly one bubble per hazard; no state change.

**FLUSH**
- Outputs: `if_id_flush` = 1, `pipeline_stall` = 1, `pc_write` = 1.
- `flush_cnt` decrements each cycle; return to RUN after the cycle in which `flush_cnt` = 1 is consumed.
- `load_use` is ignored.
- On `mem_miss`: freeze outputs apply, `flush_cnt` holds, next state MEM_WAIT with `ret_state` = FLUSH.

**MEM_WAIT**
- While `!mem_ready`: freeze outputs apply; `wait_cnt` increments.
- In the cycle `mem_ready` = 1: freeze releases and outputs follow the rules of `ret_state` evaluated with current inputs. Next state is `ret_state`, except FLUSH with `flush_cnt` = 0 goes to RUN.
- `wait_cnt` clears on exit.
- `mem_timeout_err` sets when `wait_cnt` == `MEM_TIMEOUT` and stays set until `rst`.
- A branch in EX during the wait remains held in EX and is serviced in the release cycle.

## Timing
- Stall, flush and hold outputs are combinational from state and inputs, with zero-cycle latency to the stage registers.
- State, counters and error flag update on `posedge clk`.
- Reset (synchronous):
  - Internal: state RUN, `flush_cnt` = 0, `wait_cnt` = 0, `ret_state` = RUN.
  - Outputs while `rst` is high: `pc_write` = 0, `if_id_write` = 0; every other output, including all perf counters, = 0.
- `rst` asserted mid-MEM_WAIT or mid-FLUSH aborts it and clears all state next edge.
- A load-use hazard costs 1 cycle.
- A taken branch costs `BRANCH_PENALTY` flushed IF/ID slots.
- A memory wait costs the number of cycles with `mem_ready` = 0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Three 32-bit saturating counters, reset to 0.
  - `perf_stall_cycles` counts cycles with `pc_write` = 0.
  - `perf_flush_events` counts taken branches serviced.
  - `perf_load_use_events` counts load-use bubbles.
- `HAZARD_PERF_CNT_EN` undefined: perf ports remain and are tied to 0; no counter logic is generated.

## Structure
- Shared package `riscv_pipe_pkg` holds:
  - the FSM state encoding;
  - `NOP_INSTR` = 32'h00000013;
  - the ALU NOP code 4'hF;
  - the `BRANCH_PENALTY` legal-range constants.
- Sub-module `sat_counter32` (enable, synchronous clear, saturating at 32'hFFFFFFFF) is instantiated three times under the macro.

## Test plan
- Load-use: `ex_mem_read` = 1, `ex_rd_addr` = 5, `id_rs2_addr` = 5, `id_uses_rs2` = 1 -> exactly one cycle of `pipeline_stall` = 1 and `pc_write` = 0; `perf_load_use_events` = 1. The same stimulus with `ex_rd_addr` = 0 -> no stall.
- Branch with `BRANCH_PENALTY` = 3: one-cycle `ex_branch_taken` pulse -> `if_id_flush` = 1 for 3 consecutive cycles, then RUN; a concurrent load-use produces no extra bubble.
- Memory wait: `mem_req_valid` = 1 with `mem_ready` low for 4 cycles -> `id_ex_hold` = 1 for those 4 cycles and released in the `mem_ready` cycle; `perf_stall_cycles` = 4.
- Miss during FLUSH (`BRANCH_PENALTY` = 3) after the first flush cycle -> MEM_WAIT, then 2 more flush cycles after release.
- Timeout with `MEM_TIMEOUT` = 8: `mem_ready` held low for 10 cycles -> `mem_timeout_err` rises after the 8th wait cycle and stays high until `rst`.
- Synchronous reset asserted in MEM_WAIT -> next cycle state RUN, all counters 0, `mem_timeout_err` = 0.
